// File: rtl/axis_fifo_pkg.sv
// Shared types and constants for the FifoCore read-side AXI4-Stream adapter.
package axis_fifo_pkg;

   localparam int DLEN_DEFAULT = 8;
   localparam int BUF_DEPTH    = 3;

   typedef logic [1:0] buf_ptr_t;
   typedef logic [1:0] buf_cnt_t;

   // Circular pointer advance; the buffer is not a power of two deep.
   function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
      return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/axis_rd_skid_buf.sv
// Three-entry circular prefetch buffer: push at tail, pop at head, registered head data.
module axis_rd_skid_buf
   import axis_fifo_pkg::*;
#(
   parameter int DLEN = DLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            push,
   input  logic [DLEN-1:0] push_data,
   input  logic            pop,
   output buf_cnt_t        count,
   output logic [DLEN-1:0] head_data
);

   logic [DLEN-1:0] mem_q [BUF_DEPTH];
   logic [DLEN-1:0] mem_d [BUF_DEPTH];
   buf_ptr_t        head_q, head_d;
   buf_ptr_t        tail_q, tail_d;
   buf_cnt_t        count_q, count_d;

   // The caller never pushes when full nor pops when empty.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         mem_d[tail_q] = push_data;
         tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
         head_d = ptr_inc(head_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign head_data = mem_q[head_q];

endmodule

// File: rtl/axis_fifo_rd_adapter.sv
// FifoCore read port (pulse read, 1-cycle latency) to AXI4-Stream master.
// Optional TLAST framing with macro AXIS_RD_ADAPTER_TLAST_EN (PKT_LEN beats per packet).
module axis_fifo_rd_adapter
   import axis_fifo_pkg::*;
#(
   parameter int DLEN = DLEN_DEFAULT
`ifdef AXIS_RD_ADAPTER_TLAST_EN
   ,
   parameter int PKT_LEN = 16
`endif
) (
   input  logic            clk,
   input  logic            rstn,
   output logic            o_fifo_ren,
   input  logic [DLEN-1:0] i_fifo_rdata,
   input  logic            i_fifo_rempty,
   output logic            m_axis_tvalid,
   input  logic            m_axis_tready,
   output logic [DLEN-1:0] m_axis_tdata
`ifdef AXIS_RD_ADAPTER_TLAST_EN
   ,
   output logic            m_axis_tlast
`endif
);

   // Handshake: a beat transfers on a rising edge where tvalid && tready; tvalid and
   // tdata come only from registers, and tready reaches nothing but register inputs.
   logic     inflight_q, inflight_d;
   logic     fifo_ren;
   logic     room;
   logic     pop;
   buf_cnt_t buf_count;

   // A read is only issued when its data is guaranteed a slot on arrival.
   assign room = ({1'b0, buf_count} + {2'b00, inflight_q}) < 3'(BUF_DEPTH);

   always_comb begin
      fifo_ren   = !i_fifo_rempty && room;
      inflight_d = fifo_ren;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) inflight_q <= 1'b0;
      else       inflight_q <= inflight_d;
   end

   assign o_fifo_ren    = fifo_ren;
   assign m_axis_tvalid = (buf_count != '0);
   assign pop           = m_axis_tvalid && m_axis_tready;

   axis_rd_skid_buf #(
      .DLEN(DLEN)
   ) u_buf (
      .clk      (clk),
      .rstn     (rstn),
      .push     (inflight_q),
      .push_data(i_fifo_rdata),
      .pop      (pop),
      .count    (buf_count),
      .head_data(m_axis_tdata)
   );

`ifdef AXIS_RD_ADAPTER_TLAST_EN
   localparam int BW = $clog2(PKT_LEN) + 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

   logic [BW-1:0] beat_q, beat_d;

   always_comb begin
      beat_d = beat_q;
      if (pop) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) beat_q <= '0;
      else       beat_q <= beat_d;
   end

   assign m_axis_tlast = (beat_q == LAST_BEAT) && m_axis_tvalid;
`endif

endmodule

// File: tb/tb_axis_fifo_rd_adapter.sv
// Bench for axis_fifo_rd_adapter with a behavioural FifoCore read port and a scoreboard.
// Build with AXIS_RD_ADAPTER_TLAST_EN defined to also check TLAST framing (PKT_LEN=4).
module tb_axis_fifo_rd_adapter;

   localparam int DLEN = 8;
`ifdef AXIS_RD_ADAPTER_TLAST_EN
   localparam int PKT_LEN = 4;
`endif

   logic            clk;
   logic            rstn;
   logic            o_fifo_ren;
   logic [DLEN-1:0] fifo_rdata;
   logic            fifo_rempty;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic [DLEN-1:0] m_axis_tdata;
`ifdef AXIS_RD_ADAPTER_TLAST_EN
   logic            m_axis_tlast;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DLEN-1:0] exp_q[$];
   logic [DLEN-1:0] wr_pending[$];
   logic [DLEN-1:0] fifo_mem[$];
   bit              underflow_seen = 0;
   bit              stall_prev = 0;
   logic [DLEN-1:0] stall_data = '0;
`ifdef AXIS_RD_ADAPTER_TLAST_EN
   int              tb_beat = 0;
   logic [DLEN-1:0] last_q[$];
`endif

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   axis_fifo_rd_adapter #(
      .DLEN(DLEN)
`ifdef AXIS_RD_ADAPTER_TLAST_EN
      ,
      .PKT_LEN(PKT_LEN)
`endif
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .o_fifo_ren   (o_fifo_ren),
      .i_fifo_rdata (fifo_rdata),
      .i_fifo_rempty(fifo_rempty),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tdata (m_axis_tdata)
`ifdef AXIS_RD_ADAPTER_TLAST_EN
      ,
      .m_axis_tlast (m_axis_tlast)
`endif
   );

   // ---------------- FifoCore read-port model ----------------
   // One write per cycle from wr_pending; registered read data the cycle after ren.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fifo_mem.delete();
         fifo_rdata  <= '0;
         fifo_rempty <= 1'b1;
      end else begin
         if (o_fifo_ren) begin
            if (fifo_mem.size() == 0) underflow_seen = 1;
            else                      fifo_rdata <= fifo_mem.pop_front();
         end
         if (wr_pending.size() != 0) fifo_mem.push_back(wr_pending.pop_front());
         fifo_rempty <= (fifo_mem.size() == 0);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at the falling edge, after inputs for the coming rising edge are set.
   task automatic monitor();
      if (!rstn) begin
         stall_prev = 0;
`ifdef AXIS_RD_ADAPTER_TLAST_EN
         tb_beat = 0;
`endif
         return;
      end
      check("ren_while_empty", 32'(o_fifo_ren && fifo_rempty), 32'd0);
      if (stall_prev) begin
         check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
         check("hold_tdata", 32'(m_axis_tdata), 32'(stall_data));
      end
`ifdef AXIS_RD_ADAPTER_TLAST_EN
      if (m_axis_tvalid) check("tlast", 32'(m_axis_tlast), 32'(tb_beat == PKT_LEN - 1));
`endif
      if (m_axis_tvalid && m_axis_tready) begin
         check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("sb_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
`ifdef AXIS_RD_ADAPTER_TLAST_EN
         if (m_axis_tlast) last_q.push_back(m_axis_tdata);
         tb_beat = (tb_beat == PKT_LEN - 1) ? 0 : tb_beat + 1;
`endif
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      monitor();
      @(negedge clk);
   endtask

   task automatic push_word(input logic [DLEN-1:0] d);
      wr_pending.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic drain(input string tag, input int max_cycles, input bit rnd_ready);
      for (int i = 0; i < max_cycles; i++) begin
         if (exp_q.size() == 0 && wr_pending.size() == 0) break;
         m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (m_axis_tvalid) break;
         step();
      end
      check(tag, 32'(m_axis_tvalid), 32'd1);
   endtask

   task automatic reset_pulse();
      rstn = 1'b0;
      exp_q.delete();
      wr_pending.delete();
      step();
      rstn = 1'b1;
      step();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int remaining;
      logic [DLEN-1:0] d;

      rstn          = 1'b0;
      m_axis_tready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ren", 32'(o_fifo_ren), 32'd0);
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tdata", 32'(m_axis_tdata), 32'd0);
      rstn = 1'b1;
      step();

      // Single beat: ren once, tvalid two cycles after ren for one cycle.
      m_axis_tready = 1'b1;
      push_word(8'hA5);
      step();
      check("single_ren", 32'(o_fifo_ren), 32'd1);
      step();
      check("single_ren_drop", 32'(o_fifo_ren), 32'd0);
      check("single_no_early_valid", 32'(m_axis_tvalid), 32'd0);
      step();
      check("single_valid", 32'(m_axis_tvalid), 32'd1);
      check("single_data", 32'(m_axis_tdata), 32'hA5);
      step();
      check("single_valid_drop", 32'(m_axis_tvalid), 32'd0);
      check("single_rempty", 32'(fifo_rempty), 32'd1);

      // Streaming: 16 beats with no bubbles once the first arrives.
      for (int i = 0; i < 16; i++) push_word(8'(i));
      wait_valid("stream_first_valid", 10);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (m_axis_tvalid) n++;
         step();
      end
      check("stream_no_bubbles", 32'(n), 32'd16);
      check("stream_sb_empty", 32'(exp_q.size()), 32'd0);
      check("stream_valid_end", 32'(m_axis_tvalid), 32'd0);

      // Backpressure: only three reads are absorbed while tready is low.
      m_axis_tready = 1'b0;
      for (int i = 0; i < 16; i++) push_word(8'(i));
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (o_fifo_ren) n++;
      end
      check("bp_ren_count", 32'(n), 32'd3);
      check("bp_buf_count", 32'(dut.u_buf.count_q), 32'd3);
      check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("bp_tdata", 32'(m_axis_tdata), 32'h00);
      drain("bp_drain", 200, 1'b0);

      // Random writes and random tready over 64 beats.
      remaining = 64;
      for (int i = 0; i < 3000; i++) begin
         if (remaining == 0 && exp_q.size() == 0) break;
         if (remaining > 0 && $urandom_range(0, 1) == 1) begin
            d = 8'($urandom_range(0, 255));
            push_word(d);
            remaining--;
         end
         m_axis_tready = 1'($urandom_range(0, 1));
         step();
      end
      check("rand_all_sent", 32'(remaining), 32'd0);
      check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
      check("no_underflow", 32'(underflow_seen), 32'd0);

      // Reset mid-stream with two beats buffered.
      m_axis_tready = 1'b0;
      push_word(8'h11);
      push_word(8'h22);
      repeat (6) step();
      check("mid_buffered", 32'(dut.u_buf.count_q), 32'd2);
      rstn = 1'b0;
      exp_q.delete();
      wr_pending.delete();
      step();
      check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("mid_rst_ren", 32'(o_fifo_ren), 32'd0);
      check("mid_rst_count", 32'(dut.u_buf.count_q), 32'd0);
      rstn = 1'b1;
      step();
      m_axis_tready = 1'b1;
      push_word(8'h3C);
      wait_valid("post_rst_valid", 10);
      check("post_rst_data", 32'(m_axis_tdata), 32'h3C);
      drain("post_rst_drain", 20, 1'b0);

`ifdef AXIS_RD_ADAPTER_TLAST_EN
      // Framing: PKT_LEN=4, tlast on 0x13 and 0x17 even while stalled.
      reset_pulse();
      last_q.delete();
      m_axis_tready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
      repeat (8) step();
      drain("tlast_drain", 300, 1'b1);
      check("tlast_count", 32'(last_q.size()), 32'd2);
      if (last_q.size() == 2) begin
         check("tlast_first", 32'(last_q[0]), 32'h13);
         check("tlast_second", 32'(last_q[1]), 32'h17);
      end
`else
      reset_pulse();
      check("final_idle_valid", 32'(m_axis_tvalid), 32'd0);
`endif

      check("final_underflow", 32'(underflow_seen), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
